// File: rtl/fifo_ptr_bank_pkg.sv
// fifo_pkg: shared types and helpers for the multi-channel FIFO pointer bank.
//   ptr_width() : pointer/level width for a given per-channel address width
//                 (one extra MSB distinguishes full from empty).
//   ch_width()  : channel-select width, never narrower than 1 bit.
//   ptr_t/level_t : default-sized pointer and level types.
//   flag_idx_e  : bit positions of the per-channel status flag vector.
package fifo_pkg;

  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  localparam int DEF_ADDR_WIDTH = 4;

  typedef logic [ptr_width(DEF_ADDR_WIDTH)-1:0] ptr_t;
  typedef logic [ptr_width(DEF_ADDR_WIDTH)-1:0] level_t;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    FULL   = 2'd1,
    AFULL  = 2'd2,
    AEMPTY = 2'd3
  } flag_idx_e;

endpackage

// File: rtl/fifo_ptr_chan.sv
// fifo_ptr_chan: one logical FIFO's write/read pointers, fill level, status
// flags and sticky overflow/underflow errors.
// Optional feature macro: FIFO_PTR_BANK_WATERMARK_EN (adds hwm_clr / hwm).
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   push_req, pop_req   push/pop addressed to this channel
//   flush               drop contents (rptr <- wptr), dominates push/pop
//   err_clr             clear sticky ovf/unf (a same-cycle error wins)
//   wr_ok, rd_ok        push/pop accepted this cycle
//   wr_idx, rd_idx      RAM address bits of the write/read pointers
//   level               fill count; empty/full/afull/aempty flags
//   ovf, unf            sticky overflow/underflow
//   hwm_clr, hwm        watermark clear / max level (feature only)
module fifo_ptr_chan
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH    = 4,
  parameter int AFULL_THRESH  = 2**ADDR_WIDTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push_req,
  input  logic                  pop_req,
  input  logic                  flush,
  input  logic                  err_clr,
`ifdef FIFO_PTR_BANK_WATERMARK_EN
  input  logic                  hwm_clr,
  output logic [ADDR_WIDTH:0]   hwm,
`endif
  output logic                  wr_ok,
  output logic                  rd_ok,
  output logic [ADDR_WIDTH-1:0] wr_idx,
  output logic [ADDR_WIDTH-1:0] rd_idx,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  empty,
  output logic                  full,
  output logic                  afull,
  output logic                  aempty,
  output logic                  ovf,
  output logic                  unf
);

  typedef logic [ptr_width(ADDR_WIDTH)-1:0] cptr_t;

  localparam cptr_t DEPTH    = cptr_t'(1 << ADDR_WIDTH);
  localparam cptr_t AF_LIM   = cptr_t'(AFULL_THRESH);
  localparam cptr_t AE_LIM   = cptr_t'(AEMPTY_THRESH);
  // Reset state: empty and (level 0 <= threshold) almost-empty.
  localparam logic [3:0] FLAGS_RST = 4'b1001;

  cptr_t      wptr_p0, rptr_p0, level_p0;
  cptr_t      wptr_p1, rptr_p1, level_p1;
  logic [3:0] flags_p0, flags_p1;
  logic       ovf_p0, unf_p0, ovf_p1, unf_p1;

  // Stage p0: acceptance from registered flags, next pointers and flags
  always_comb begin
    flags_p0 = '0;
    wr_ok    = push_req & ~flags_p1[FULL]  & ~flush;
    rd_ok    = pop_req  & ~flags_p1[EMPTY] & ~flush;
    wptr_p0  = wptr_p1 + cptr_t'(wr_ok);
    rptr_p0  = flush ? wptr_p1 : rptr_p1 + cptr_t'(rd_ok);
    // Modular subtraction; the extra MSB makes a full FIFO read as DEPTH.
    level_p0 = wptr_p0 - rptr_p0;
    flags_p0[EMPTY]  = (level_p0 == '0);
    flags_p0[FULL]   = (level_p0 == DEPTH);
    flags_p0[AFULL]  = (level_p0 >= AF_LIM);
    flags_p0[AEMPTY] = (level_p0 <= AE_LIM);
    // Flush-caused rejections are intentional and never flagged.
    ovf_p0 = (ovf_p1 & ~err_clr) | (push_req & flags_p1[FULL]  & ~flush);
    unf_p0 = (unf_p1 & ~err_clr) | (pop_req  & flags_p1[EMPTY] & ~flush);
  end

  // Stage p1: registered pointers, level and flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_p1  <= '0;
      rptr_p1  <= '0;
      level_p1 <= '0;
      flags_p1 <= FLAGS_RST;
      ovf_p1   <= 1'b0;
      unf_p1   <= 1'b0;
    end else begin
      wptr_p1  <= wptr_p0;
      rptr_p1  <= rptr_p0;
      level_p1 <= level_p0;
      flags_p1 <= flags_p0;
      ovf_p1   <= ovf_p0;
      unf_p1   <= unf_p0;
    end
  end

`ifdef FIFO_PTR_BANK_WATERMARK_EN
  cptr_t hwm_p1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hwm_p1 <= '0;
    end else if (hwm_clr || (level_p0 > hwm_p1)) begin
      hwm_p1 <= level_p0;
    end
  end

  assign hwm = hwm_p1;
`endif

  assign wr_idx = wptr_p1[ADDR_WIDTH-1:0];
  assign rd_idx = rptr_p1[ADDR_WIDTH-1:0];
  assign level  = level_p1;
  assign empty  = flags_p1[EMPTY];
  assign full   = flags_p1[FULL];
  assign afull  = flags_p1[AFULL];
  assign aempty = flags_p1[AEMPTY];
  assign ovf    = ovf_p1;
  assign unf    = unf_p1;

endmodule

// File: rtl/fifo_ptr_bank.sv
// fifo_ptr_bank: single-clock pointer controller for NUM_CH logical FIFOs
// sharing one RAM partitioned by channel index (address = {ch, ptr}).
// Optional feature macro: FIFO_PTR_BANK_WATERMARK_EN (adds hwm_clr / hwm).
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   push, push_ch              one push per cycle on any channel
//   pop, pop_ch                one pop per cycle on any channel
//   flush[NUM_CH]              per-channel flush
//   err_clr                    clear all sticky errors
//   wr_en, wr_addr             RAM write strobe/address (combinational)
//   rd_en, rd_addr             RAM read strobe/address (combinational)
//   level                      packed per-channel fill counts
//   empty/full/afull/aempty    per-channel flags
//   ovf/unf                    per-channel sticky overflow/underflow
//   hwm_clr, hwm               watermark clear / packed max levels (feature only)
module fifo_ptr_bank
  import fifo_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int ADDR_WIDTH    = 4,
  parameter int AFULL_THRESH  = 2**ADDR_WIDTH - 2,
  parameter int AEMPTY_THRESH = 2,
  localparam int CH_W         = ch_width(NUM_CH),
  localparam int LW           = ptr_width(ADDR_WIDTH)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [CH_W-1:0]            push_ch,
  input  logic                       pop,
  input  logic [CH_W-1:0]            pop_ch,
  input  logic [NUM_CH-1:0]          flush,
  input  logic                       err_clr,
`ifdef FIFO_PTR_BANK_WATERMARK_EN
  input  logic                       hwm_clr,
  output logic [NUM_CH*LW-1:0]       hwm,
`endif
  output logic                       wr_en,
  output logic [CH_W+ADDR_WIDTH-1:0] wr_addr,
  output logic                       rd_en,
  output logic [CH_W+ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_CH*LW-1:0]       level,
  output logic [NUM_CH-1:0]          empty,
  output logic [NUM_CH-1:0]          full,
  output logic [NUM_CH-1:0]          afull,
  output logic [NUM_CH-1:0]          aempty,
  output logic [NUM_CH-1:0]          ovf,
  output logic [NUM_CH-1:0]          unf
);

  // Slot arrays cover every encodable channel index so the address muxes
  // never index out of range; slots beyond NUM_CH are tied off.
  localparam int NSLOT = 1 << CH_W;

  logic [NSLOT-1:0]      wr_ok_v, rd_ok_v;
  logic [ADDR_WIDTH-1:0] wr_idx_v [NSLOT];
  logic [ADDR_WIDTH-1:0] rd_idx_v [NSLOT];

  for (genvar g = 0; g < NSLOT; g++) begin : g_slot
    if (g < NUM_CH) begin : g_chan
      fifo_ptr_chan #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .AFULL_THRESH  (AFULL_THRESH),
        .AEMPTY_THRESH (AEMPTY_THRESH)
      ) u_chan (
        .clk      (clk),
        .reset_n  (reset_n),
        .push_req (push & (push_ch == CH_W'(g))),
        .pop_req  (pop  & (pop_ch  == CH_W'(g))),
        .flush    (flush[g]),
        .err_clr  (err_clr),
`ifdef FIFO_PTR_BANK_WATERMARK_EN
        .hwm_clr  (hwm_clr),
        .hwm      (hwm[g*LW +: LW]),
`endif
        .wr_ok    (wr_ok_v[g]),
        .rd_ok    (rd_ok_v[g]),
        .wr_idx   (wr_idx_v[g]),
        .rd_idx   (rd_idx_v[g]),
        .level    (level[g*LW +: LW]),
        .empty    (empty[g]),
        .full     (full[g]),
        .afull    (afull[g]),
        .aempty   (aempty[g]),
        .ovf      (ovf[g]),
        .unf      (unf[g])
      );
    end else begin : g_pad
      assign wr_ok_v[g]  = 1'b0;
      assign rd_ok_v[g]  = 1'b0;
      assign wr_idx_v[g] = '0;
      assign rd_idx_v[g] = '0;
    end
  end

  // At most one channel can accept each request, so OR-reduction is the mux.
  assign wr_en   = |wr_ok_v;
  assign rd_en   = |rd_ok_v;
  assign wr_addr = {push_ch, wr_idx_v[push_ch]};
  assign rd_addr = {pop_ch,  rd_idx_v[pop_ch]};

endmodule

// File: tb/tb_fifo_ptr_bank.sv
module tb_fifo_ptr_bank;

  localparam int NUM_CH = 4;
  localparam int AW     = 3;
  localparam int LW     = AW + 1;
  localparam int CH_W   = 2;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 push, pop, err_clr;
  logic [CH_W-1:0]      push_ch, pop_ch;
  logic [NUM_CH-1:0]    flush;
  logic                 wr_en, rd_en;
  logic [CH_W+AW-1:0]   wr_addr, rd_addr;
  logic [NUM_CH*LW-1:0] level;
  logic [NUM_CH-1:0]    empty, full, afull, aempty, ovf, unf;
`ifdef FIFO_PTR_BANK_WATERMARK_EN
  logic                 hwm_clr;
  logic [NUM_CH*LW-1:0] hwm;
`endif

  int errors = 0;
  int checks = 0;
  logic [CH_W+AW-1:0] exp_q[$];
  logic [CH_W+AW-1:0] exp_a;

  always #5 clk = ~clk;

  fifo_ptr_bank #(
    .NUM_CH(NUM_CH), .ADDR_WIDTH(AW), .AFULL_THRESH(6), .AEMPTY_THRESH(2)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .push(push), .push_ch(push_ch), .pop(pop), .pop_ch(pop_ch),
    .flush(flush), .err_clr(err_clr),
`ifdef FIFO_PTR_BANK_WATERMARK_EN
    .hwm_clr(hwm_clr), .hwm(hwm),
`endif
    .wr_en(wr_en), .wr_addr(wr_addr), .rd_en(rd_en), .rd_addr(rd_addr),
    .level(level), .empty(empty), .full(full), .afull(afull), .aempty(aempty),
    .ovf(ovf), .unf(unf)
  );

  function automatic logic [LW-1:0] lvl(input int ch);
    return level[ch*LW +: LW];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    push = 1'b0; pop = 1'b0; flush = '0; err_clr = 1'b0;
  endtask

  task automatic test_reset();
    // Traffic on ch1/ch2, then reset asserted mid-cycle while push is high.
    for (int i = 0; i < 3; i++) begin
      push = 1'b1; push_ch = 2'(1 + (i % 2));
      step();
    end
    #2;
    reset_n = 1'b0;
    #1;
    if (level !== '0) begin errors++; $display("FAIL reset_level: got %0h want 0", level); end
    checks++;
    if (empty !== 4'hF) begin errors++; $display("FAIL reset_empty: got %0h want f", empty); end
    checks++;
    if (aempty !== 4'hF) begin errors++; $display("FAIL reset_aempty: got %0h want f", aempty); end
    checks++;
    if ({full, afull, ovf, unf} !== '0) begin
      errors++; $display("FAIL reset_flags: full=%0h afull=%0h ovf=%0h unf=%0h want 0", full, afull, ovf, unf);
    end
    checks++;
    idle();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({2'd2, 3'(i)});
      push = 1'b1; push_ch = 2'd2;
      #1;
      exp_a = exp_q.pop_front();
      if (wr_en !== 1'b1 || wr_addr !== exp_a) begin
        errors++; $display("FAIL fill_wr[%0d]: wr_en=%0b addr=%0h want 1/%0h", i, wr_en, wr_addr, exp_a);
      end
      checks++;
      step();
      if (lvl(2) !== LW'(i + 1) || afull[2] !== ((i + 1) >= 6)) begin
        errors++; $display("FAIL fill_lvl[%0d]: level=%0d afull=%0b want %0d/%0b", i, lvl(2), afull[2], i + 1, (i + 1) >= 6);
      end
      checks++;
    end
    if (full[2] !== 1'b1) begin errors++; $display("FAIL fill_full: got %0b want 1", full[2]); end
    checks++;
    // Ninth push: rejected, overflow recorded.
    #1;
    if (wr_en !== 1'b0) begin errors++; $display("FAIL ovf_wr_en: got %0b want 0", wr_en); end
    checks++;
    step();
    if (ovf[2] !== 1'b1 || lvl(2) !== 4'd8) begin
      errors++; $display("FAIL ovf_flag: ovf=%0b level=%0d want 1/8", ovf[2], lvl(2));
    end
    checks++;
    // Push+pop on full channel: pop accepted, push rejected.
    pop = 1'b1; pop_ch = 2'd2;
    exp_q.push_back(5'h10);
    #1;
    exp_a = exp_q.pop_front();
    if (wr_en !== 1'b0 || rd_en !== 1'b1 || rd_addr !== exp_a) begin
      errors++; $display("FAIL full_pushpop: wr_en=%0b rd_en=%0b rd_addr=%0h want 0/1/%0h", wr_en, rd_en, rd_addr, exp_a);
    end
    checks++;
    step();
    if (lvl(2) !== 4'd7 || full[2] !== 1'b0) begin
      errors++; $display("FAIL full_pushpop_lvl: level=%0d full=%0b want 7/0", lvl(2), full[2]);
    end
    checks++;
    idle();
    flush[2] = 1'b1;
    step();
    idle();
  endtask

  task automatic test_same_cycle();
    for (int i = 0; i < 3; i++) begin
      push = 1'b1; push_ch = 2'd1;
      step();
    end
    push = 1'b1; push_ch = 2'd1; pop = 1'b1; pop_ch = 2'd1;
    exp_q.push_back(5'h08);
    exp_q.push_back(5'h0B);
    #1;
    exp_a = exp_q.pop_front();
    if (rd_en !== 1'b1 || rd_addr !== exp_a) begin
      errors++; $display("FAIL same_rd: rd_en=%0b rd_addr=%0h want 1/%0h", rd_en, rd_addr, exp_a);
    end
    checks++;
    exp_a = exp_q.pop_front();
    if (wr_en !== 1'b1 || wr_addr !== exp_a) begin
      errors++; $display("FAIL same_wr: wr_en=%0b wr_addr=%0h want 1/%0h", wr_en, wr_addr, exp_a);
    end
    checks++;
    step();
    if (lvl(1) !== 4'd3) begin errors++; $display("FAIL same_level: got %0d want 3", lvl(1)); end
    checks++;
    idle();
    flush[1] = 1'b1;
    step();
    idle();
  endtask

  task automatic test_underflow();
    pop = 1'b1; pop_ch = 2'd0;
    #1;
    if (rd_en !== 1'b0) begin errors++; $display("FAIL unf_rd_en: got %0b want 0", rd_en); end
    checks++;
    step();
    if (unf[0] !== 1'b1) begin errors++; $display("FAIL unf_set: got %0b want 1", unf[0]); end
    checks++;
    err_clr = 1'b1;
    step();
    if (unf[0] !== 1'b1) begin errors++; $display("FAIL unf_clr_race: got %0b want 1", unf[0]); end
    checks++;
    pop = 1'b0;
    step();
    if (unf !== 4'h0 || ovf !== 4'h0) begin
      errors++; $display("FAIL err_clr: unf=%0h ovf=%0h want 0/0", unf, ovf);
    end
    checks++;
    idle();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      push = 1'b1; push_ch = 2'd3;
      step();
    end
    if (lvl(3) !== 4'd5) begin errors++; $display("FAIL flush_pre: got %0d want 5", lvl(3)); end
    checks++;
    flush[3] = 1'b1;
    #1;
    if (wr_en !== 1'b0) begin errors++; $display("FAIL flush_wr_en: got %0b want 0", wr_en); end
    checks++;
    step();
    if (lvl(3) !== 4'd0 || empty[3] !== 1'b1 || aempty[3] !== 1'b1 || ovf[3] !== 1'b0) begin
      errors++; $display("FAIL flush_post: level=%0d empty=%0b aempty=%0b ovf=%0b want 0/1/1/0", lvl(3), empty[3], aempty[3], ovf[3]);
    end
    checks++;
    idle();
  endtask

  task automatic test_back_to_back();
    push = 1'b1; push_ch = 2'd0;
    exp_q.push_back(5'h00);
    #1;
    exp_a = exp_q.pop_front();
    if (wr_en !== 1'b1 || wr_addr !== exp_a) begin
      errors++; $display("FAIL b2b_first: wr_en=%0b wr_addr=%0h want 1/%0h", wr_en, wr_addr, exp_a);
    end
    checks++;
    step();
    for (int k = 0; k < 20; k++) begin
      pop = 1'b1; pop_ch = 2'd0;
      exp_q.push_back({2'd0, 3'(k % 8)});
      exp_q.push_back({2'd0, 3'((k + 1) % 8)});
      #1;
      exp_a = exp_q.pop_front();
      if (rd_en !== 1'b1 || rd_addr !== exp_a) begin
        errors++; $display("FAIL b2b_rd[%0d]: rd_en=%0b rd_addr=%0h want 1/%0h", k, rd_en, rd_addr, exp_a);
      end
      checks++;
      exp_a = exp_q.pop_front();
      if (wr_en !== 1'b1 || wr_addr !== exp_a) begin
        errors++; $display("FAIL b2b_wr[%0d]: wr_en=%0b wr_addr=%0h want 1/%0h", k, wr_en, wr_addr, exp_a);
      end
      checks++;
      step();
      if (lvl(0) !== 4'd1 || empty[0] !== 1'b0) begin
        errors++; $display("FAIL b2b_lvl[%0d]: level=%0d empty=%0b want 1/0", k, lvl(0), empty[0]);
      end
      checks++;
    end
    idle();
`ifdef FIFO_PTR_BANK_WATERMARK_EN
    if (hwm[0 +: LW] !== 4'd1) begin errors++; $display("FAIL hwm0: got %0d want 1", hwm[0 +: LW]); end
    checks++;
`endif
  endtask

  initial begin
    reset_n = 1'b0;
    push_ch = '0; pop_ch = '0;
    idle();
`ifdef FIFO_PTR_BANK_WATERMARK_EN
    hwm_clr = 1'b0;
`endif
    step();
    step();
    reset_n = 1'b1;
    step();
    test_reset();
    test_fill();
    test_same_cycle();
    test_underflow();
    test_flush();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_ptr_bank.md
Name: fifo_ptr_bank

Overview:
Single-clock, multi-channel FIFO pointer controller. It manages NUM_CH independent logical FIFOs, each 2**ADDR_WIDTH deep, stored in one shared RAM partitioned by channel index. It accepts at most one push and one pop per cycle, on any channels, and drives the RAM write and read addresses. It reports per-channel level, full/empty, almost thresholds and sticky overflow/underflow errors. It generalises the two-pointer extra-MSB FIFO scheme used in the dual-clock path.

Parameters:
NUM_CH, 4, number of logical FIFOs; must be ≥1.
ADDR_WIDTH, 4, per-channel RAM address width; depth is 2**ADDR_WIDTH.
AFULL_THRESH, 2**ADDR_WIDTH-2, afull asserts when level ≥ this value.
AEMPTY_THRESH, 2, aempty asserts when level ≤ this value.

Ports:
clk  in  1  clock; all signals synchronous to it.
reset_n  in  1  asynchronous active-low reset.
push  in  1  write request.
push_ch  in  CH_W  channel for push; CH_W = max(1,$clog2(NUM_CH)).
pop  in  1  read request.
pop_ch  in  CH_W  channel for pop.
flush  in  NUM_CH  per-channel synchronous flush.
err_clr  in  1  clears all sticky error flags.
wr_en  out  1  RAM write strobe (push accepted).
wr_addr  out  CH_W+ADDR_WIDTH  {push_ch, wptr[push_ch][ADDR_WIDTH-1:0]}.
rd_en  out  1  RAM read strobe (pop accepted).
rd_addr  out  CH_W+ADDR_WIDTH  {pop_ch, rptr[pop_ch][ADDR_WIDTH-1:0]}.
level  out  NUM_CH*(ADDR_WIDTH+1)  packed per-channel fill count.
empty, full, afull, aempty  out  NUM_CH each  per-channel flags.
ovf, unf  out  NUM_CH each  sticky overflow/underflow.

Behaviour:
- Reset (async assert, sync deassert handled upstream): all pointers 0. level=0, empty=all 1, aempty=all 1 (AEMPTY_THRESH≥0), full=0, afull=0, ovf=unf=0.
- Per channel: wptr and rptr are ADDR_WIDTH+1 bits wide. level = wptr - rptr (mod 2**(ADDR_WIDTH+1)). empty = (level==0). full = (level==2**ADDR_WIDTH).
- Acceptance is combinational from the registered flags:
  - wr_en = push & ~full[push_ch] & ~flush[push_ch]
  - rd_en = pop & ~empty[pop_ch] & ~flush[pop_ch]
- Addresses are combinational. Pointers, level and flags update on the next clk edge, so latency is 1 cycle.
- Push and pop on the same channel:
  - Both accepted: pointers both advance and level is unchanged.
  - Channel full: push is rejected even if the pop is accepted.
  - Channel empty: pop is rejected even if the push is accepted.
- Rejected push sets ovf[push_ch]; rejected pop sets unf[pop_ch]. A flush-caused rejection sets neither flag.
- Flush: rptr ← wptr and level → 0 next cycle. Flush dominates a same-cycle push or pop on that channel. Other channels are unaffected.
- err_clr clears ovf/unf next cycle. A new error in the same cycle as err_clr wins (flag stays 1).
- Wrap-around: the pointer MSB toggles every 2**ADDR_WIDTH accesses. RAM address bits wrap naturally, with no extra logic.
- afull and aempty are registered, derived from the next-state level.

Optional Feature:
FIFO_PTR_BANK_WATERMARK_EN
- Defined:
  - Adds input hwm_clr (1 bit) and output hwm (NUM_CH*(ADDR_WIDTH+1)).
  - hwm[ch] records the maximum level since reset or hwm_clr, updated the cycle after level changes.
  - If hwm_clr is asserted, hwm[ch] loads the current next-state level.
- Undefined: ports are absent and no watermark registers are built.

Decomposition:
- Package fifo_pkg holds:
  - ptr_t/level_t typedefs parameterised via a ptr_width function;
  - the CH_W computation helper;
  - the flag index enum {EMPTY,FULL,AFULL,AEMPTY}.
- Sub-module fifo_ptr_chan holds one channel's pointers, level, flags, error and watermark. fifo_ptr_bank generates NUM_CH instances and holds the arbitration and address muxing.

Test Plan (NUM_CH=4, ADDR_WIDTH=3, AFULL_THRESH=6, AEMPTY_THRESH=2):
1. Reset with reset_n=0 mid-traffic → immediately level=0 on all channels, empty=4'hF, aempty=4'hF, full=0, ovf=unf=0.
2. 8 pushes to ch2:
   - wr_addr steps 0x10..0x17; afull[2] rises after the 6th push; level[2]=8, full[2]=1.
   - 9th push → wr_en=0, ovf[2]=1, level[2] stays 8.
3. ch1 at level 3, push ch1 + pop ch1 in the same cycle → wr_en=rd_en=1, level[1] stays 3, rd_addr={01,rptr}.
4. Pop on empty ch0 → rd_en=0, unf[0]=1. Then err_clr together with another empty pop on ch0 → unf[0] stays 1. err_clr alone → unf[0]=0 next cycle.
5. ch3 at level 5, flush[3] with same-cycle push ch3 → wr_en=0, ovf[3]=0, next cycle level[3]=0, empty[3]=1.
6. 20 push/pop pairs on ch0 → rd_addr wraps 0x07→0x00 and the pointer MSB toggles; level[0] stays at 1 after the first push; with WATERMARK_EN, hwm[0]=1.
